// File: rtl/uart_rx_fsm.sv
// UART receive frame controller: sequences start/data/parity/stop phases and the counter, sampler and checker strobes.
// Strobes are combinational from state and edge_cnt; result pulses are registered one cycle after STOP/LAST. No backpressure.
module uart_rx_fsm #(
    parameter int OVERSAMPLE = 8,
    parameter int EDGE_W     = 3,
    parameter int BIT_W      = 4,
    parameter int DATA_W     = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              RX_IN,
    input  logic              PAR_EN,
    input  logic [EDGE_W-1:0] edge_cnt,
    input  logic [BIT_W-1:0]  bit_cnt,
    input  logic              strt_glitch,
    input  logic              par_err,
    input  logic              stp_err,
    output logic              cnt_enable,
    output logic              cnt_clr,
    output logic              dat_samp_en,
    output logic              deser_en,
    output logic              strt_chk_en,
    output logic              par_chk_en,
    output logic              stp_chk_en,
    output logic              data_valid,
    output logic              parity_error,
    output logic              frame_error
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t state_q;
    state_t state_d;
    logic   par_en_q;
    logic   par_lat_q;
    logic   chk;
    logic   last;
    logic   stop_done;
    logic   frame_start;

    assign chk         = (edge_cnt == EDGE_W'(OVERSAMPLE - 2));
    assign last        = (edge_cnt == EDGE_W'(OVERSAMPLE - 1));
    assign stop_done   = (state_q == STOP) && last;
    // A new frame begins either from the idle line or directly out of the stop bit.
    assign frame_start = !RX_IN && ((state_q == IDLE) || stop_done);

    always_comb begin
        state_d     = state_q;
        cnt_enable  = 1'b0;
        cnt_clr     = 1'b0;
        dat_samp_en = 1'b0;
        deser_en    = 1'b0;
        strt_chk_en = 1'b0;
        par_chk_en  = 1'b0;
        stp_chk_en  = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_clr = 1'b1;
                if (!RX_IN) state_d = START;
            end
            START: begin
                cnt_enable  = 1'b1;
                dat_samp_en = 1'b1;
                strt_chk_en = chk;
                if (last) state_d = strt_glitch ? IDLE : DATA;
            end
            DATA: begin
                cnt_enable  = 1'b1;
                dat_samp_en = 1'b1;
                deser_en    = chk;
                if (last && (bit_cnt == BIT_W'(DATA_W)))
                    state_d = par_en_q ? PARITY : STOP;
            end
            PARITY: begin
                cnt_enable  = 1'b1;
                dat_samp_en = 1'b1;
                par_chk_en  = chk;
                if (last) state_d = STOP;
            end
            STOP: begin
                cnt_enable  = 1'b1;
                dat_samp_en = 1'b1;
                stp_chk_en  = chk;
                if (last) begin
                    cnt_clr = 1'b1;
                    state_d = RX_IN ? IDLE : START;
                end
            end
            default: state_d = IDLE;
        endcase
        // While reset is asserted the outputs look like IDLE regardless of the state register.
        if (!RST) begin
            cnt_clr     = 1'b1;
            cnt_enable  = 1'b0;
            dat_samp_en = 1'b0;
            deser_en    = 1'b0;
            strt_chk_en = 1'b0;
            par_chk_en  = 1'b0;
            stp_chk_en  = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q      <= IDLE;
            par_en_q     <= 1'b0;
            par_lat_q    <= 1'b0;
            data_valid   <= 1'b0;
            parity_error <= 1'b0;
            frame_error  <= 1'b0;
        end else begin
            state_q <= state_d;
            if ((state_q == IDLE) && !RX_IN) par_en_q <= PAR_EN;
            if (frame_start)
                par_lat_q <= 1'b0;
            else if ((state_q == PARITY) && last)
                par_lat_q <= par_err;
            // Stop error outranks parity error; a good frame needs neither.
            frame_error  <= stop_done && stp_err;
            parity_error <= stop_done && !stp_err && par_lat_q;
            data_valid   <= stop_done && !stp_err && !par_lat_q;
        end
    end

endmodule
